// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Issues one word-aligned read at a time, holds the returned word for decode
// until it is accepted, and handles redirects that arrive while a read is in
// flight by dropping the stale response (DROP state).
// Optional build macro: FETCH_CNT_EN adds a 32-bit accepted-instruction counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [24:0] dec_imm,
    output logic [6:0]  dec_opcode
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_VALID,
        S_DROP
    } state_t;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ALIGN    = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PA = RESET_PC & ALIGN;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drop_addr;    // address of the read being drained in DROP
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [31:0] target;
    logic        load_ir;
    logic        load_drop;

    assign target     = redirect_target & ALIGN;
    assign dec_instr  = ir;
    assign dec_pc     = ir_pc;
    assign dec_imm    = ir[31:7];
    assign dec_opcode = ir[6:0];

    // Next-state, next-pc and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nxt = state;
        pc_nxt    = pc;
        load_ir   = 1'b0;
        load_drop = 1'b0;
        imem_req  = 1'b0;
        imem_addr = pc;
        dec_valid = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = ~rst;
                if (redirect) begin
                    pc_nxt = target;
                    if (!imem_ack) begin
                        // Read still outstanding: keep its address on the bus until it returns.
                        load_drop = 1'b1;
                        state_nxt = S_DROP;
                    end
                end else if (imem_ack) begin
                    load_ir   = 1'b1;
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                dec_valid = ~rst;
                // Redirect has priority over a same-cycle acceptance.
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = S_REQ;
                end else if (dec_ready) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                imem_req  = ~rst;
                imem_addr = drop_addr;
                if (redirect) begin
                    pc_nxt = target;
                end
                if (imem_ack) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // State register and fetch datapath; reset wins over every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PA;
            drop_addr <= RESET_PA;
            ir        <= NOP;
            ir_pc     <= RESET_PA;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_drop) begin
                drop_addr <= pc;
            end
            if (load_ir) begin
                ir    <= imem_rdata;
                ir_pc <= pc;
            end
        end
    end

`ifdef FETCH_CNT_EN
    // Count instructions accepted by decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
        end else if (dec_valid && dec_ready) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`else
    // Counter not built: no fetch_cnt port and no counter state.
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: imem_req  out  1  instruction-memory read request.
REQ-005 Port: imem_addr  out  32  word-aligned fetch address.
REQ-006 Port: imem_ack  in  1  memory response valid; imem_rdata is sampled in the same cycle.
REQ-007 Port: imem_rdata  in  32  fetched instruction word.
REQ-008 Port: redirect  in  1  branch/jump taken, load new PC.
REQ-009 Port: redirect_target  in  32  new PC; bits [1:0] ignored and forced to 00.
REQ-010 Port: dec_valid  out  1  instruction available to decode.
REQ-011 Port: dec_ready  in  1  decode accepts the instruction.
REQ-012 Port: dec_instr  out  32  held instruction register.
REQ-013 Port: dec_pc  out  32  PC of dec_instr.
REQ-014 Port: dec_imm  out  25  dec_instr[31:7], the opcode-stripped field consumed by the immediate generator.
REQ-015 Port: dec_opcode  out  7  dec_instr[6:0].

Function
REQ-016 FSM states SHALL be REQ, VALID and DROP.
REQ-017 REQ: imem_req=1, imem_addr=pc; on imem_ack, capture imem_rdata into IR, set dec_pc=pc, and go to VALID.
REQ-018 imem_req and imem_addr SHALL stay constant until imem_ack; a request SHALL never be withdrawn or re-addressed before ack.
REQ-019 VALID: dec_valid=1 and imem_req=0; when dec_ready=1, pc<=pc+4 (mod 2^32, wrapping 32'hFFFF_FFFC to 0) and go to REQ.
REQ-020 Latency: ack at cycle N gives dec_valid=1 at N+1; handshake at cycle M gives imem_req=1 at M+1 with the next address.
REQ-021 dec_instr, dec_pc, dec_imm and dec_opcode SHALL remain stable while dec_valid=1 and dec_ready=0.
REQ-022 Redirect in VALID: pc<=target, dec_valid=0 next cycle, go to REQ; redirect overrides a same-cycle dec_ready, so pc+4 is not applied.
REQ-023 Redirect in REQ with imem_ack=1: discard rdata, pc<=target, stay in REQ.
REQ-024 Redirect in REQ with imem_ack=0: pc<=target, go to DROP.
REQ-025 DROP: imem_req=1 with the old address held; on imem_ack, discard rdata and go to REQ with the updated pc.
REQ-026 A further redirect in DROP SHALL overwrite the pending pc; the last redirect wins.
REQ-027 dec_valid SHALL be 0 in REQ and DROP.

Reset
REQ-028 During rst=1: state=REQ, pc=RESET_PC, imem_req=0, dec_valid=0, dec_instr=32'h0000_0013 (NOP), dec_pc=RESET_PC, and any counter=0.
REQ-029 First cycle after rst deasserts: imem_req=1 and imem_addr=RESET_PC.
REQ-030 rst SHALL override redirect and handshake inputs; mid-request reset abandons the request, with the memory required to tolerate this.

Configuration
REQ-031 Macro FETCH_CNT_EN defined: adds output fetch_cnt (32 bits), incremented on each dec_valid&dec_ready cycle, wrapping to 0, reset to 0.
REQ-032 Macro FETCH_CNT_EN undefined: port fetch_cnt and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Reset, zero-wait memory (ack in the request cycle), dec_ready=1 -> imem_addr 0x0,0x4,0x8 on alternate cycles; dec_pc follows the same sequence.
REQ-034 Ack delayed 3 cycles -> imem_req and imem_addr=0x4 held for 4 cycles; dec_valid rises on the cycle after ack.
REQ-035 dec_ready=0 for 5 cycles with instr 0xFE010113 -> dec_instr, dec_imm=0x1FC0202 and dec_opcode=0x13 stable; no new request.
REQ-036 Redirect to 0x103 in VALID with dec_ready=1 -> next imem_addr=0x100, not pc+4.
REQ-037 Redirect to 0x200 in REQ (addr 0x8) without ack, ack 2 cycles later -> addr 0x8 held, rdata dropped, then request 0x200; no dec_valid for 0x8.
REQ-038 With FETCH_CNT_EN: 7 handshakes, then reset -> fetch_cnt=7, then 0.
